// File: rtl/boost_duty_sequencer.sv
// Slew-limited duty sequencer for the boost PWM: soft-start, tracking, soft-stop
// and latched fault shutdown, with duty updates only on PWM-period ticks.
module boost_duty_sequencer #(
  parameter int TICK_DIV = 400,
  parameter int STEP     = 8,
  parameter int DMAX     = 900
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [9:0] d_target,
  input  logic       fault_in,
  input  logic       fault_clr,
  output logic [9:0] d_boost,
  output logic       tick,
  output logic       ramp_done,
  output logic       fault_latched,
  output logic [2:0] state
);

  localparam int          CW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] DMAX_W = 11'(DMAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    STOP  = 3'd3,
    FAULT = 3'd4
  } st_t;

  st_t         st_q, st_eff, st_nx;
  logic [CW-1:0] cnt_q;
  logic [10:0] d_ext, tgt, up, dn, slew;
  logic [9:0]  d_nx;
  logic        rd_nx, flt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt_q <= '0;
    else if (cnt_q == CW'(TICK_DIV-1))  cnt_q <= '0;
    else                                cnt_q <= cnt_q + 1'b1;
  end

  assign tick = (cnt_q == CW'(TICK_DIV-1));

  // 11-bit arithmetic so step-up cannot wrap before the clamp
  assign d_ext = {1'b0, d_boost};
  assign tgt   = ({1'b0, d_target} > DMAX_W) ? DMAX_W : {1'b0, d_target};
  assign up    = d_ext + STEP_W;
  assign dn    = (d_ext > STEP_W) ? d_ext - STEP_W : 11'd0;
  assign slew  = (tgt > d_ext) ? ((up > tgt) ? tgt : up) :
                 (tgt < d_ext) ? ((dn < tgt) ? tgt : dn) : d_ext;

  always_comb begin
    st_eff = st_q;
    flt_nx = fault_latched;
    // ce-driven transition first; a coincident tick then uses the new state's rule
    case (st_q)
      IDLE:     if (ce && !fault_latched) st_eff = RAMP;
      RAMP,
      RUN:      if (!ce) st_eff = STOP;
      STOP:     if (ce) st_eff = RAMP;
      FAULT:    if (fault_clr && !fault_in && !ce) begin
                  st_eff = IDLE;
                  flt_nx = 1'b0;
                end
      default:  st_eff = IDLE;
    endcase

    st_nx = st_eff;
    d_nx  = d_boost;
    rd_nx = 1'b0;
    if (tick) begin
      case (st_eff)
        RAMP: begin
          d_nx = slew[9:0];
          if (slew == tgt) begin
            st_nx = RUN;
            rd_nx = 1'b1;
          end
        end
        RUN:  d_nx = slew[9:0];
        STOP: begin
          d_nx = dn[9:0];
          if (dn == 11'd0) st_nx = IDLE;
        end
        default: d_nx = d_boost;
      endcase
    end
    if (st_eff == IDLE || st_eff == FAULT) d_nx = '0;

    if (fault_in && st_q != FAULT) begin
      st_nx  = FAULT;
      d_nx   = '0;
      rd_nx  = 1'b0;
      flt_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= IDLE;
      d_boost       <= '0;
      ramp_done     <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      st_q          <= st_nx;
      d_boost       <= d_nx;
      ramp_done     <= rd_nx;
      fault_latched <= flt_nx;
    end
  end

  assign state = st_q;

endmodule

// File: doc/boost_duty_sequencer.md
Name: boost_duty_sequencer

Overview:
Sequences the 10-bit duty command into the boost PWM/dead-time stage. Performs slew-limited soft-start, tracking and soft-stop, and forces a fault shutdown. Duty changes are applied only on PWM-period ticks, so the PWM never sees a mid-period step larger than STEP. Sits between the control firmware/regulator and the d_boost input of the boost PWM.

Parameters:
TICK_DIV, 400, clk cycles per update tick (400 x 10 ns = one 4 us PWM period)
STEP, 8, maximum duty change per tick (LSBs of 10-bit duty)
DMAX, 900, duty clamp ceiling (must be <= 1023)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ce  input  1  run enable; 1 = start/run, 0 = soft-stop
d_target  input  10  requested duty
fault_in  input  1  level fault (overcurrent/overvoltage), active high
fault_clr  input  1  fault acknowledge, active high
d_boost  output  10  duty command to PWM, registered
tick  output  1  one-clk pulse at each update point
ramp_done  output  1  one-clk pulse when soft-start first reaches target
fault_latched  output  1  sticky fault flag
state  output  3  current FSM state encoding

Behaviour:
- Reset (rst_n=0, asynchronous): d_boost=0, tick=0, ramp_done=0, fault_latched=0, state=IDLE, tick counter=0.
- Tick counter: free-running 0..TICK_DIV-1, independent of state. tick=1 for the single cycle where count==TICK_DIV-1; count then wraps to 0.
- Effective target tgt = min(d_target, DMAX), sampled only on tick cycles.
- Slew rule, evaluated on a tick: if tgt > d, then d = min(d+STEP, tgt); if tgt < d, then d = max(d-STEP, tgt); otherwise hold. Use an 11-bit intermediate with no wrap; step-down saturates at 0.
- State encoding: IDLE=0, RAMP=1, RUN=2, STOP=3, FAULT=4.
- IDLE: d_boost held at 0. If ce=1 and fault_latched=0, go to RAMP on the next edge. No tick wait is needed to leave IDLE.
- RAMP: apply the slew rule on each tick. When the result equals tgt, go to RUN and pulse ramp_done in the same cycle d_boost reaches tgt. If ce=0, go to STOP.
- RUN: apply the slew rule on each tick so that d_boost tracks tgt. If ce=0, go to STOP. ramp_done is not re-asserted.
- STOP: on each tick, d = max(d-STEP, 0). When d reaches 0, go to IDLE. If ce returns to 1 during STOP, go to RAMP and ramp up from the current d (no jump).
- FAULT entry: fault_in=1 in any state except FAULT forces the following on the next edge: d_boost=0, fault_latched=1, state=FAULT. This overrides all other transitions and does not wait for a tick.
- FAULT: d_boost held at 0. Exit to IDLE only when fault_clr=1, fault_in=0 and ce=0 in the same cycle; fault_latched clears on that edge. fault_clr under any other condition is ignored.
- Simultaneous events:
  - fault_in beats ce and tick.
  - A tick and a ce change in the same cycle: the state transition is taken and the slew step is applied using the new state's rule (STOP steps down; RAMP steps toward tgt).
- d_target=0 in RUN: d_boost slews down to 0 and stays in RUN.
- d_target>DMAX: d_boost clamps at DMAX.

Test Plan:
Use TICK_DIV=8, STEP=16, DMAX=900 for all scenarios.
- Reset/idle: hold rst_n=0, then release with ce=0 -> d_boost=0, state=0, tick every 8 clk, no ramp_done.
- Soft-start: ce=1, d_target=100 -> d_boost steps 16,32,...,96,100 on ticks 1..7. ramp_done pulses once at 100, state=2, d_boost stays 100.
- Tracking and clamp: in RUN at 100, set d_target=1023 -> d_boost rises 16/tick and stops at 900. Then d_target=890 -> 890 within one tick.
- Soft-stop and restart: in RUN at 900, ce=0 -> d_boost falls 16/tick. At 500, set ce=1 -> state=1 and ramp resumes from 500 (no jump). Finally ce=0 until d_boost reaches 0 -> state=0.
- Fault: in RAMP at 64, pulse fault_in mid-period -> next edge d_boost=0, fault_latched=1, state=4.
  - fault_clr with ce=1 -> stays in FAULT.
  - fault_clr with ce=0 and fault_in=0 -> IDLE, flag clears.
- Async reset mid-ramp: assert rst_n=0 between clk edges at d_boost=48 -> outputs go to reset values immediately, without a clock edge.
